// File: rtl/iter_shifter_if.sv
// Handshake/data bundle between a requester and the iterative shifter.
//   start, a, shamt, mode : request side (driven by master)
//   busy, done, y         : status and result (driven by slave)
interface iter_shifter_if #(
  parameter int N       = 32,
  parameter int SHAMT_W = 5
) ();
  logic               start;
  logic [N-1:0]       a;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         mode;
  logic               busy;
  logic               done;
  logic [N-1:0]       y;

  modport master (
    output start, a, shamt, mode,
    input  busy, done, y
  );

  modport slave (
    input  start, a, shamt, mode,
    output busy, done, y
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shift unit: shifts an N-bit operand by shamt positions, at most
// STEP positions per clock. Modes: 00 SLL, 01 SRL, 11 SRA, 10 ROL.
// Ports:
//   clk  - clock, all state changes on rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of iter_shifter_if (start/a/shamt/mode in,
//          busy/done/y out); y holds its value between done pulses.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; zero-amount shifts complete from here
// SHIFT | working register shifting k=min(STEP,rem) bits per edge
module iter_shifter #(
  parameter int N       = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic         clk,
  input  logic         rst,
  iter_shifter_if.slave bus
);

  // rem never exceeds N-1, so STEP beyond that behaves like N-1 and the
  // per-edge amount always fits in SHAMT_W bits.
  localparam int STEP_LIM = (STEP > N - 1) ? N - 1 : STEP;
  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP_LIM);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_n;
  logic [N-1:0]       work_q, work_n;
  logic [SHAMT_W-1:0] rem_q, rem_n;
  logic [1:0]         mode_q, mode_n;
  logic [N-1:0]       y_q, y_n;
  logic               done_q, done_n;

  logic [SHAMT_W-1:0] k;
  logic [2*N-1:0]     dbl;
  logic [N-1:0]       shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      work_q  <= work_n;
      rem_q   <= rem_n;
      mode_q  <= mode_n;
      y_q     <= y_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    k   = (rem_q > STEP_K) ? STEP_K : rem_q;
    // Rotate via a doubled word: the upper half after the shift is the
    // operand rotated left by k.
    dbl = {work_q, work_q} << k;
    case (mode_q)
      2'b00:   shifted = work_q << k;
      2'b01:   shifted = work_q >> k;
      // work_q was loaded with a, and arithmetic shifts keep the MSB, so
      // the MSB is always the original sign bit.
      2'b11:   shifted = $signed(work_q) >>> k;
      default: shifted = dbl[2*N-1:N];
    endcase
  end

  always_comb begin
    state_n = state_q;
    work_n  = work_q;
    rem_n   = rem_q;
    mode_n  = mode_q;
    y_n     = y_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.shamt == '0) begin
            y_n    = bus.a;
            done_n = 1'b1;
          end else begin
            work_n  = bus.a;
            rem_n   = bus.shamt;
            mode_n  = bus.mode;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_n = shifted;
        rem_n  = rem_q - k;
        if (rem_q == k) begin
          y_n     = shifted;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.y    = y_q;

endmodule
